// File: rtl/spi_ram_slave_param.sv
// SPI slave with an embedded single-port RAM, sampled on the system clock.
// Each frame is a direction bit, a 2-bit command and a payload; read data returns MSB first on MISO.
module spi_ram_slave_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter bit AUTO_INC = 1'b1
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic frame_err
);

   localparam int PAYLOAD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int FRAME_W   = 2 + PAYLOAD_W;
   localparam int CNT_W     = $clog2(FRAME_W + DATA_W + 2);

   // bit_cnt_q runs through shift-in, the rx_valid cycle, the tx_valid cycle and the read-out bits
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] RX_CNT   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(FRAME_W + DATA_W);
   localparam logic [CNT_W-1:0] TX_DONE  = CNT_W'(FRAME_W + DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [FRAME_W-1:0] shift_q;
   logic               rx_valid_q;
   logic               tx_valid_q;
   logic [DATA_W-1:0]  tx_q;
   logic [DATA_W-1:0]  dout_q;
   logic               miso_q;
   logic               frame_err_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic               rd_addr_ok_q;
   logic [DATA_W-1:0]  mem_q [2**ADDR_W];

   logic [FRAME_W-1:0] word_d;
   logic [1:0]         new_cmd;
   logic [1:0]         rx_cmd;
   logic               cmd_legal;

   assign word_d  = {shift_q[FRAME_W-2:0], MOSI};
   assign new_cmd = word_d[FRAME_W-1 -: 2];
   assign rx_cmd  = shift_q[FRAME_W-1 -: 2];

   assign cmd_legal = ((state_q == WRITE)     && !new_cmd[1])
                   || ((state_q == READ_ADD)  && (new_cmd == 2'b10))
                   || ((state_q == READ_DATA) && (new_cmd == 2'b11));

   assign MISO      = miso_q;
   assign frame_err = frame_err_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         rx_valid_q   <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_q         <= '0;
         miso_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         rd_addr_ok_q <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         tx_valid_q  <= rx_valid_q && (rx_cmd == 2'b11);

         // A completed word is committed even if SS_n rises on its rx_valid cycle
         if (rx_valid_q) begin
            unique case (rx_cmd)
               2'b00: wr_addr_q <= shift_q[ADDR_W-1:0];
               2'b01: if (AUTO_INC) wr_addr_q <= wr_addr_q + 1'b1;
               2'b10: begin
                  rd_addr_q    <= shift_q[ADDR_W-1:0];
                  rd_addr_ok_q <= 1'b1;
               end
               default: if (AUTO_INC) rd_addr_q <= rd_addr_q + 1'b1;
            endcase
         end

         if ((state_q != IDLE) && SS_n) begin
            state_q   <= IDLE;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (!SS_n) begin
                     state_q   <= CHK_CMD;
                     bit_cnt_q <= '0;
                  end
               end
               CHK_CMD: begin
                  bit_cnt_q <= '0;
                  if (!MOSI)             state_q <= WRITE;
                  else if (rd_addr_ok_q) state_q <= READ_DATA;
                  else                   state_q <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (bit_cnt_q < RX_CNT) begin
                     shift_q   <= word_d;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == LAST_BIT) begin
                        rx_valid_q  <= cmd_legal;
                        frame_err_q <= !cmd_legal;
                     end
                  end else if ((state_q != READ_DATA) || (bit_cnt_q == RX_CNT && frame_err_q)) begin
                     state_q   <= IDLE;
                     bit_cnt_q <= '0;
                  end else if (bit_cnt_q == RX_CNT) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (bit_cnt_q == TX_DONE) begin
                     miso_q    <= 1'b0;
                     state_q   <= IDLE;
                     bit_cnt_q <= '0;
                  end else begin
                     // First read-out bit comes straight from dout_q on the tx_valid cycle
                     miso_q    <= tx_valid_q ? dout_q[DATA_W-1] : tx_q[DATA_W-1];
                     tx_q      <= tx_valid_q ? (dout_q << 1) : (tx_q << 1);
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if ((bit_cnt_q == TX_LAST) && !AUTO_INC) rd_addr_ok_q <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // NOTE: RAM and its read register have no reset; contents must survive rst_n.
   always_ff @(posedge CLK) begin
      if (rx_valid_q && (rx_cmd == 2'b01)) mem_q[wr_addr_q] <= shift_q[DATA_W-1:0];
      if (rx_valid_q && (rx_cmd == 2'b11)) dout_q <= mem_q[rd_addr_q];
   end

endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Randomised frame-level bench for spi_ram_slave_param: one auto-increment and one static instance,
// each followed by a transaction model that predicts MISO and frame_err for every clock.
module tb_spi_ram_slave_param;

   localparam int DW = 8;
   localparam int F  = 10;

   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   logic ss1_n = 1'b1;
   logic ss0_n = 1'b1;
   logic MOSI = 1'b0;
   logic miso1, err1, miso0, err0;

   always #5 CLK = ~CLK;

   // sel 1: AUTO_INC=1 instance, sel 0: AUTO_INC=0 instance
   spi_ram_slave_param #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) dut_inc (
      .CLK(CLK), .rst_n(rst_n), .SS_n(ss1_n), .MOSI(MOSI), .MISO(miso1), .frame_err(err1));
   spi_ram_slave_param #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b0)) dut_static (
      .CLK(CLK), .rst_n(rst_n), .SS_n(ss0_n), .MOSI(MOSI), .MISO(miso0), .frame_err(err0));

   typedef struct {
      bit m1, e1, m0, e0, cap;
      int sel;
   } exp_t;

   exp_t exp_q[$];
   exp_t ce;

   int n_vec = 0;
   int n_bad = 0;
   int err_cnt1 = 0;
   int err_cnt0 = 0;
   logic [7:0] obs1 = '0;
   logic [7:0] obs0 = '0;

   logic [7:0] m_mem [2][256];
   logic [7:0] m_wr [2];
   logic [7:0] m_rd [2];
   bit         m_ok [2];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Every clock with a queued expectation is compared here
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            check("miso_inc", miso1, ce.m1);
            check("ferr_inc", err1, ce.e1);
            check("miso_static", miso0, ce.m0);
            check("ferr_static", err0, ce.e0);
            if (err1 === 1'b1) err_cnt1++;
            if (err0 === 1'b1) err_cnt0++;
            if (ce.cap && ce.sel == 1) obs1 = {obs1[6:0], miso1};
            if (ce.cap && ce.sel == 0) obs0 = {obs0[6:0], miso0};
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_wr[s] = '0;
         m_rd[s] = '0;
         m_ok[s] = 1'b0;
      end
   endtask

   task automatic cycle(input int sel, input bit rst, input bit ss, input bit mosi,
                        input bit em, input bit ee, input bit cap);
      exp_t e;
      @(negedge CLK);
      rst_n = ~rst;
      ss1_n = (sel == 1) ? ss : 1'b1;
      ss0_n = (sel == 0) ? ss : 1'b1;
      MOSI  = mosi;
      e.sel = sel;
      e.cap = cap;
      e.m1  = (sel == 1) ? em : 1'b0;
      e.e1  = (sel == 1) ? ee : 1'b0;
      e.m0  = (sel == 0) ? em : 1'b0;
      e.e0  = (sel == 0) ? ee : 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic reset_pulse();
      cycle(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      cycle(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One master frame: SS_n low for the length a correct master would use, then gap idle cycles.
   task automatic frame(input int sel, input bit dir, input logic [1:0] cmd, input logic [7:0] pay,
                        input int abort_at, input bit abort_rst, input int gap);
      bit legal, long_f, aborted, mosi, em, ee, cap;
      logic [7:0] rdata;
      logic [F-1:0] word;
      int n_low;
      if (!dir)             legal = !cmd[1];
      else if (!m_ok[sel])  legal = (cmd == 2'b10);
      else                  legal = (cmd == 2'b11);
      long_f  = dir && m_ok[sel] && legal;
      rdata   = m_mem[sel][m_rd[sel]];
      word    = {cmd, pay};
      n_low   = long_f ? 3 + F + DW : 2 + F;
      aborted = 1'b0;
      for (int k = 0; k < n_low; k++) begin
         if (k == abort_at) begin
            aborted = 1'b1;
            if (abort_rst) begin
               cycle(sel, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
               model_reset();
            end else begin
               cycle(sel, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
            end
            break;
         end
         mosi = 1'($urandom);
         if (k == 1)                 mosi = dir;
         else if (k >= 2 && k <= F + 1) mosi = word[F + 1 - k];
         ee  = (k == F + 1) && !legal;
         cap = long_f && (k >= F + 3) && (k <= F + 2 + DW);
         em  = cap ? rdata[F + 2 + DW - k] : 1'b0;
         cycle(sel, 1'b0, 1'b0, mosi, em, ee, cap);
      end
      // A word whose last bit was sampled takes effect; sel 1 post-increments
      if (!abort_rst && legal && (!aborted || abort_at >= F + 3)) begin
         case (cmd)
            2'b00: m_wr[sel] = pay;
            2'b01: begin
               m_mem[sel][m_wr[sel]] = pay;
               if (sel == 1) m_wr[sel] = m_wr[sel] + 8'd1;
            end
            2'b10: begin
               m_rd[sel] = pay;
               m_ok[sel] = 1'b1;
            end
            default: if (sel == 1) m_rd[sel] = m_rd[sel] + 8'd1;
         endcase
      end
      if (long_f && !aborted && sel == 0) m_ok[0] = 1'b0;
      if (aborted && abort_rst) cycle(sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (gap) cycle(sel, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr(input int sel, input bit is_data, input logic [7:0] v);
      frame(sel, 1'b0, {1'b0, is_data}, v, -1, 1'b0, 2);
   endtask

   task automatic rd_addr(input int sel, input logic [7:0] a);
      frame(sel, 1'b1, 2'b10, a, -1, 1'b0, 2);
   endtask

   task automatic read_expect(input int sel, input string nm, input logic [7:0] v);
      frame(sel, 1'b1, 2'b11, 8'($urandom), -1, 1'b0, 2);
      check(nm, (sel == 1) ? obs1 : obs0, v);
   endtask

   task automatic rand_ops(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         int r;
         bit dir, abr;
         logic [1:0] cmd;
         logic [7:0] pay;
         int ab;
         r   = $urandom_range(0, 11);
         pay = 8'($urandom);
         ab  = -1;
         abr = 1'b0;
         dir = 1'b0;
         cmd = 2'b00;
         case (r)
            0:       begin dir = 1'b0; cmd = 2'b00; end
            1, 2:    begin dir = 1'b0; cmd = 2'b01; end
            3:       begin dir = 1'b1; cmd = 2'b10; end
            7:       begin dir = 1'b0; cmd = {1'b1, 1'($urandom)}; end
            8:       begin dir = 1'b1; cmd = {1'b0, 1'($urandom)}; end
            9:       begin dir = 1'($urandom); cmd = 2'($urandom); ab = $urandom_range(1, F + 1); end
            10: begin
               dir = 1'b1;
               cmd = 2'b11;
               if (m_ok[sel]) begin
                  ab  = $urandom_range(F + 3, F + 2 + DW);
                  abr = 1'($urandom);
               end
            end
            default: begin dir = 1'b1; cmd = 2'b11; end
         endcase
         if (r == 11) reset_pulse();
         else frame(sel, dir, cmd, pay, ab, abr, $urandom_range(2, 3));
      end
   endtask

   initial begin
      int eb;
      model_reset();
      // Outputs held low throughout reset
      cycle(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int s = 0; s < 2; s++) begin
         wr(s, 1'b0, 8'h00);
         for (int a = 0; a < 256; a++) begin
            if (s == 0) wr(s, 1'b0, 8'(a));
            wr(s, 1'b1, 8'($urandom));
         end
      end

      // Burst write then burst read from 0x10; 0x77 must land at 0x12
      reset_pulse();
      wr(1, 1'b0, 8'h10);
      wr(1, 1'b1, 8'hA5);
      wr(1, 1'b1, 8'h3C);
      wr(1, 1'b1, 8'h77);
      rd_addr(1, 8'h10);
      read_expect(1, "burst_rd0", 8'hA5);
      read_expect(1, "burst_rd1", 8'h3C);
      read_expect(1, "burst_rd2", 8'h77);

      // Address wrap from 0xFF to 0x00
      wr(1, 1'b0, 8'hFF);
      wr(1, 1'b1, 8'h11);
      wr(1, 1'b1, 8'h22);
      reset_pulse();
      rd_addr(1, 8'hFF);
      read_expect(1, "wrap_rd0", 8'h11);
      read_expect(1, "wrap_rd1", 8'h22);

      // Write-data frame abandoned after 5 bits leaves RAM and wr_addr alone
      wr(1, 1'b0, 8'h40);
      wr(1, 1'b1, 8'h5A);
      frame(1, 1'b0, 2'b01, 8'hEE, 7, 1'b0, 2);
      wr(1, 1'b1, 8'h6B);
      reset_pulse();
      rd_addr(1, 8'h40);
      read_expect(1, "abort_rd0", 8'h5A);
      read_expect(1, "abort_rd1", 8'h6B);

      // Write direction carrying cmd 11 is rejected with one frame_err pulse
      wr(1, 1'b0, 8'h50);
      wr(1, 1'b1, 8'h99);
      eb = err_cnt1;
      frame(1, 1'b0, 2'b11, 8'h12, -1, 1'b0, 2);
      check("bad_cmd_pulses", err_cnt1 - eb, 1);
      wr(1, 1'b1, 8'hC3);
      reset_pulse();
      rd_addr(1, 8'h50);
      read_expect(1, "bad_cmd_rd0", 8'h99);
      read_expect(1, "bad_cmd_rd1", 8'hC3);

      // Reset during read-out; the next read-data frame falls into READ_ADD
      frame(1, 1'b1, 2'b11, 8'h00, F + 5, 1'b1, 2);
      eb = err_cnt1;
      frame(1, 1'b1, 2'b11, 8'h00, -1, 1'b0, 2);
      check("rst_then_read_err", err_cnt1 - eb, 1);
      rd_addr(1, 8'h10);
      read_expect(1, "rst_then_rd", 8'hA5);

      rand_ops(1, 300);

      // Static addressing: rd_addr_ok drops after one read
      reset_pulse();
      wr(0, 1'b0, 8'h05);
      wr(0, 1'b1, 8'hE7);
      rd_addr(0, 8'h05);
      read_expect(0, "static_rd0", 8'hE7);
      eb = err_cnt0;
      frame(0, 1'b1, 2'b11, 8'h00, -1, 1'b0, 2);
      check("static_rearm_err", err_cnt0 - eb, 1);
      rd_addr(0, 8'h05);
      read_expect(0, "static_rd1", 8'hE7);

      rand_ops(0, 150);

      repeat (3) cycle(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      check("expect_queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
